ym3438_pg: RTL and testbench
============================

// Module: ym3438_pg
// PURPOSE
//  Phase generator: consumes the LFO-modulated frequency number (fnum_lfo) and, per
//  operator slot, applies block shift, detune and multiple to form a 20-bit phase
//  increment, then accumulates it in a 24-slot time-multiplexed phase store.
//  Sits directly downstream of the LFO; phase_out feeds the operator/sine lookup.
// PARAMETERS
//  SLOTS      24  operator slots per cycle (6 channels x 4 operators); ring depth
//  PHASE_W    20  phase accumulator width
//  OUT_W      10  phase_out width (top bits of accumulator)
// PORTS
//  MCLK        in   1   master clock, all state rising-edge
//  IC          in   1   reset, asynchronous, active-low (clears all state)
//  slot_en     in   1   one-cycle strobe per slot step; all state advances only when 1
//  slot_sync   in   1   qualified by slot_en: current input slot is slot 0
//  fnum_lfo    in   12  LFO-modulated fnum, 1 fractional bit (fnum*2 + pm)
//  block       in   3   octave
//  det_amt     in   5   detune magnitude (precomputed from dt/kcode upstream)
//  det_sign    in   1   1 = subtract det_amt
//  multi       in   4   frequency multiple, 0 = x0.5
//  pg_reset    in   1   key-on: clear this slot's phase
//  phase_out   out  10  accumulated phase [19:10] of slot_out
//  phase_inc   out  20  increment applied to slot_out (debug/verification)
//  slot_out    out  5   slot index of phase_out, 0..23
// BEHAVIOUR
//  - IC=0: ring entries, pipeline regs, phase_out, phase_inc, slot_out -> 0, immediately
//    (async); held while IC=0; slot_en ignored. Resumes on first slot_en after IC=1.
//  - No state changes on cycles with slot_en=0; outputs hold.
//  - Stage A (slot_en at step k): base = ({5'b0,fnum_lfo} << block) >> 2, 17 bits (no
//    overflow: max 0x1FFE0); fd = det_sign ? base - det_amt : base + det_amt, mod 2^17.
//    pg_reset and slot index registered alongside.
//  - Stage B (step k+1): inc = multi==0 ? {3'b0,fd>>1} : fd*multi truncated to 20 bits.
//  - Stage C (step k+2): head = ring output (slot's stored phase); new = rst_C ? 0 :
//    (head + inc) mod 2^20; new pushed into ring; phase_out<=new[19:10]; phase_inc<=inc
//    (inc reported even when reset applied); slot_out<=slot_C.
//  - Latency: inputs at step k -> outputs valid after step k+2 edge.
//  - Ring: SLOTS-deep x PHASE_W shift register, shifts once per slot_en; slot s always
//    reaches stage C exactly SLOTS steps after its previous update.
//  - Slot counter: slot_sync & slot_en -> input slot=0; else increments, 23 wraps to 0.
//    slot_sync on a non-23 boundary realigns counter only; ring content not moved.
//  - pg_reset with no slot_en is ignored (not latched).
//  - IC asserted mid-pipeline: in-flight slots discarded, no partial writes.
// TESTING
//  1 fnum_lfo=0x400,block=4,multi=1,det=0 on slot 5 -> inc=0x01000; after 1st update
//    phase_out=4 slot_out=5; after 256 updates of slot 5 phase_out wraps to 0.
//  2 Same, multi=0 -> phase_inc=0x00800, phase_out=2 after 1 update; multi=3 -> 0x03000.
//  3 base 0x1000, det_sign=1,det_amt=5 -> inc=0x00FFB; fnum_lfo=0,det_sign=1,det_amt=1
//    -> fd=0x1FFFF, multi=1 -> inc=0x1FFFF (wrap).
//  4 fnum_lfo=0xFFF,block=7,multi=15,det=0 -> inc=0xDFE20 (20-bit truncation of 0x1DFE20).
//  5 Slot 7 accumulating, pg_reset on slot 7 -> that update phase_out=0, next=inc>>10;
//    other slots unaffected.
//  6 Drop IC mid-stream with slot_en gaps -> all outputs 0 same cycle; after release,
//    sync realigns, first outputs after 2 steps, ring starts from 0.

Source files
------------

// File: rtl/ym3438_pg.sv
// ym3438_pg: phase generator.
// Turns the LFO-modulated frequency number into a per-slot phase increment
// (block shift, detune, multiple) and accumulates it in a 24-entry
// time-multiplexed phase ring. Three-step pipeline: A = block/detune,
// B = multiple, C = accumulate and write back.
module ym3438_pg #(
    parameter int SLOTS   = 24,
    parameter int PHASE_W = 20,
    parameter int OUT_W   = 10
) (
    input  logic               MCLK,
    input  logic               IC,
    input  logic               slot_en,
    input  logic               slot_sync,
    input  logic [11:0]        fnum_lfo,
    input  logic [2:0]         block,
    input  logic [4:0]         det_amt,
    input  logic               det_sign,
    input  logic [3:0]         multi,
    input  logic               pg_reset,
    output logic [OUT_W-1:0]   phase_out,
    output logic [PHASE_W-1:0] phase_inc,
    output logic [4:0]         slot_out
);

    // Slot counter: index that the next un-synced input step will carry.
    logic [4:0]         slot_cnt_q, slot_cnt_d;
    logic [4:0]         slot_in;

    // Stage A: block-shifted, detuned frequency.
    logic [16:0]        base_a;
    logic [16:0]        fd_a;
    logic [16:0]        fd_a_q, fd_a_d;
    logic [3:0]         multi_a_q, multi_a_d;
    logic               rst_a_q, rst_a_d;
    logic [4:0]         slot_a_q, slot_a_d;

    // Stage B: increment after the frequency multiple.
    logic [PHASE_W-1:0] product_b;
    logic [PHASE_W-1:0] inc_b_q, inc_b_d;
    logic               rst_b_q, rst_b_d;
    logic [4:0]         slot_b_q, slot_b_d;

    // Stage C: accumulate against the slot's stored phase.
    logic [PHASE_W-1:0] head_c;
    logic [PHASE_W-1:0] new_c;

    // Output registers.
    logic [OUT_W-1:0]   phase_out_q, phase_out_d;
    logic [PHASE_W-1:0] phase_inc_q, phase_inc_d;
    logic [4:0]         slot_out_q, slot_out_d;

    // Phase ring: one entry per slot, shifted once per slot step.
    logic [PHASE_W-1:0] ring_q [SLOTS];
    logic [PHASE_W-1:0] ring_d [SLOTS];

    // Datapath arithmetic for all three stages.
    always_comb begin
        slot_in   = slot_sync ? 5'd0 : slot_cnt_q;
        // Shift in 19 bits so block 7 cannot lose the top bits before >>2.
        base_a    = 17'(({7'b0, fnum_lfo} << block) >> 2);
        fd_a      = det_sign ? (base_a - {12'b0, det_amt})
                             : (base_a + {12'b0, det_amt});
        product_b = {3'b0, fd_a_q} * {16'b0, multi_a_q};
        head_c    = ring_q[SLOTS-1];
        new_c     = rst_b_q ? '0 : (head_c + inc_b_q);
    end

    // Next-state for counter, pipeline and outputs; everything holds without slot_en.
    always_comb begin
        slot_cnt_d  = slot_cnt_q;
        fd_a_d      = fd_a_q;
        multi_a_d   = multi_a_q;
        rst_a_d     = rst_a_q;
        slot_a_d    = slot_a_q;
        inc_b_d     = inc_b_q;
        rst_b_d     = rst_b_q;
        slot_b_d    = slot_b_q;
        phase_out_d = phase_out_q;
        phase_inc_d = phase_inc_q;
        slot_out_d  = slot_out_q;
        if (slot_en) begin
            slot_cnt_d  = (slot_in == 5'(SLOTS-1)) ? 5'd0 : slot_in + 5'd1;
            fd_a_d      = fd_a;
            multi_a_d   = multi;
            rst_a_d     = pg_reset;
            slot_a_d    = slot_in;
            // Multiple 0 means x0.5.
            inc_b_d     = (multi_a_q == 4'd0) ? {4'b0, fd_a_q[16:1]} : product_b;
            rst_b_d     = rst_a_q;
            slot_b_d    = slot_a_q;
            phase_out_d = new_c[PHASE_W-1 -: OUT_W];
            phase_inc_d = inc_b_q;
            slot_out_d  = slot_b_q;
        end
    end

    // Ring next-state: new phase enters at the tail, the head leaves after SLOTS steps.
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_ring
        if (gi == 0) begin : g_tail
            assign ring_d[gi] = slot_en ? new_c : ring_q[gi];
        end else begin : g_body
            assign ring_d[gi] = slot_en ? ring_q[gi-1] : ring_q[gi];
        end
    end

    // State registers; IC low clears everything immediately.
    always_ff @(posedge MCLK or negedge IC) begin
        if (!IC) begin
            slot_cnt_q  <= '0;
            fd_a_q      <= '0;
            multi_a_q   <= '0;
            rst_a_q     <= 1'b0;
            slot_a_q    <= '0;
            inc_b_q     <= '0;
            rst_b_q     <= 1'b0;
            slot_b_q    <= '0;
            phase_out_q <= '0;
            phase_inc_q <= '0;
            slot_out_q  <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                ring_q[i] <= '0;
            end
        end else begin
            slot_cnt_q  <= slot_cnt_d;
            fd_a_q      <= fd_a_d;
            multi_a_q   <= multi_a_d;
            rst_a_q     <= rst_a_d;
            slot_a_q    <= slot_a_d;
            inc_b_q     <= inc_b_d;
            rst_b_q     <= rst_b_d;
            slot_b_q    <= slot_b_d;
            phase_out_q <= phase_out_d;
            phase_inc_q <= phase_inc_d;
            slot_out_q  <= slot_out_d;
            for (int i = 0; i < SLOTS; i++) begin
                ring_q[i] <= ring_d[i];
            end
        end
    end

    assign phase_out = phase_out_q;
    assign phase_inc = phase_inc_q;
    assign slot_out  = slot_out_q;

endmodule

// File: tb/tb_ym3438_pg.sv
// tb_ym3438_pg: scoreboard bench for the phase generator.
// Stimulus drives one slot per step from a per-slot table of hand-computed
// increments and pushes the expected output; the monitor pops and compares
// two steps later whenever a slot step reaches the outputs.
module tb_ym3438_pg;

    logic        MCLK = 1'b0;
    logic        IC = 1'b0;
    logic        slot_en = 1'b0;
    logic        slot_sync = 1'b0;
    logic [11:0] fnum_lfo = '0;
    logic [2:0]  block = '0;
    logic [4:0]  det_amt = '0;
    logic        det_sign = 1'b0;
    logic [3:0]  multi = '0;
    logic        pg_reset = 1'b0;
    logic [9:0]  phase_out;
    logic [19:0] phase_inc;
    logic [4:0]  slot_out;

    ym3438_pg dut (
        .MCLK      (MCLK),
        .IC        (IC),
        .slot_en   (slot_en),
        .slot_sync (slot_sync),
        .fnum_lfo  (fnum_lfo),
        .block     (block),
        .det_amt   (det_amt),
        .det_sign  (det_sign),
        .multi     (multi),
        .pg_reset  (pg_reset),
        .phase_out (phase_out),
        .phase_inc (phase_inc),
        .slot_out  (slot_out)
    );

    always #5 MCLK = ~MCLK;

    typedef struct packed {
        logic [4:0]  slot;
        logic [19:0] inc;
        logic [9:0]  ph;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Per-slot stimulus table with the hand-computed increment for each entry.
    logic [11:0] c_fnum [24];
    logic [2:0]  c_blk  [24];
    logic [4:0]  c_da   [24];
    logic        c_ds   [24];
    logic [3:0]  c_mul  [24];
    logic        c_rst  [24];
    logic [19:0] c_inc  [24];

    // Stored phase per ring position (input step index mod 24).
    logic [19:0] model_ph [24];
    int          step_idx = 0;
    logic [4:0]  tb_slot_next = '0;
    logic        use_gaps = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic set_slot(input int s, input logic [11:0] f, input logic [2:0] b,
                            input logic [4:0] da, input logic ds, input logic [3:0] m,
                            input logic [19:0] inc);
        c_fnum[s] = f; c_blk[s] = b; c_da[s] = da; c_ds[s] = ds; c_mul[s] = m;
        c_rst[s] = 1'b0; c_inc[s] = inc;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 24; i++) model_ph[i] = '0;
        step_idx = 0;
        tb_slot_next = '0;
        exp_q.delete();
    endtask

    // One slot step, optionally preceded by idle cycles carrying junk inputs.
    task automatic do_step(input logic sync);
        logic [4:0]  s;
        logic [19:0] nph;
        int          pos;
        exp_t        e;
        int          ngap;
        ngap = (use_gaps && ($urandom_range(0, 3) == 0)) ? int'($urandom_range(1, 2)) : 0;
        repeat (ngap) begin
            @(negedge MCLK);
            slot_en = 1'b0; pg_reset = 1'b1; slot_sync = 1'b1;
            fnum_lfo = 12'($urandom); multi = 4'($urandom); det_amt = 5'($urandom);
        end
        @(negedge MCLK);
        s = sync ? 5'd0 : tb_slot_next;
        slot_en = 1'b1; slot_sync = sync;
        fnum_lfo = c_fnum[s]; block = c_blk[s]; det_amt = c_da[s];
        det_sign = c_ds[s]; multi = c_mul[s]; pg_reset = c_rst[s];
        @(posedge MCLK);
        pos = step_idx % 24;
        nph = c_rst[s] ? 20'd0 : model_ph[pos] + c_inc[s];
        model_ph[pos] = nph;
        e.slot = s; e.inc = c_inc[s]; e.ph = nph[19:10];
        exp_q.push_back(e);
        step_idx++;
        tb_slot_next = (s == 5'd23) ? 5'd0 : s + 5'd1;
    endtask

    task automatic rounds(input int n);
        repeat (n) begin
            for (int i = 0; i < 24; i++) do_step(i == 0);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_phase_out"}, 32'(phase_out), 32'd0);
        chk({tag, "_phase_inc"}, 32'(phase_inc), 32'd0);
        chk({tag, "_slot_out"},  32'(slot_out),  32'd0);
    endtask

    // Monitor: compares on every slot step that reaches the outputs, checks hold otherwise.
    initial begin
        logic en_s;
        logic ic_s;
        int   fill;
        exp_t e;
        exp_t last;
        fill = 0;
        last = '0;
        forever begin
            @(posedge MCLK);
            en_s = slot_en;
            ic_s = IC;
            #1;
            if (!ic_s || !IC) begin
                fill = 0;
                last = '0;
                continue;
            end
            if (en_s) begin
                fill++;
                if (fill < 3) begin
                    e = '0;
                end else if (exp_q.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL scoreboard_empty: actual=output step required=queued vector (t=%0t)", $time);
                    continue;
                end else begin
                    e = exp_q.pop_front();
                end
                chk("slot_out",  32'(slot_out),  32'(e.slot));
                chk("phase_inc", 32'(phase_inc), 32'(e.inc));
                chk("phase_out", 32'(phase_out), 32'(e.ph));
                last = e;
            end else begin
                chk("hold_slot_out",  32'(slot_out),  32'(last.slot));
                chk("hold_phase_inc", 32'(phase_inc), 32'(last.inc));
                chk("hold_phase_out", 32'(phase_out), 32'(last.ph));
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 24; i++) set_slot(i, 12'h000, 3'd0, 5'd0, 1'b0, 4'd1, 20'h00000);
        clear_model();

        // Reset held: slot_en toggles must not disturb anything.
        repeat (2) @(negedge MCLK);
        slot_en = 1'b1; fnum_lfo = 12'hFFF; block = 3'd7; multi = 4'd15;
        repeat (3) @(negedge MCLK);
        chk_zero("reset");
        slot_en = 1'b0;
        @(negedge MCLK);
        IC = 1'b1;

        // Slot 5: base 0x1000, x1 -> inc 0x01000; 256 updates wrap the phase to 0.
        set_slot(5, 12'h400, 3'd4, 5'd0, 1'b0, 4'd1, 20'h01000);
        rounds(1);
        use_gaps = 1'b1;
        rounds(255);

        // Multiple, detune and truncation corners on several slots at once.
        set_slot(5,  12'h400, 3'd4, 5'd0, 1'b0, 4'd0,  20'h00800);
        set_slot(6,  12'h400, 3'd4, 5'd0, 1'b0, 4'd3,  20'h03000);
        set_slot(7,  12'h400, 3'd4, 5'd0, 1'b0, 4'd1,  20'h01000);
        set_slot(8,  12'h400, 3'd4, 5'd0, 1'b0, 4'd1,  20'h01000);
        set_slot(9,  12'h400, 3'd4, 5'd5, 1'b1, 4'd1,  20'h00FFB);
        set_slot(10, 12'h000, 3'd0, 5'd1, 1'b1, 4'd1,  20'h1FFFF);
        set_slot(11, 12'hFFF, 3'd7, 5'd0, 1'b0, 4'd15, 20'hDFE20);
        set_slot(12, 12'h400, 3'd4, 5'd3, 1'b0, 4'd0,  20'h00801);
        rounds(2);

        // Key-on on slot 7: that update reads 0, the next one inc>>10.
        c_rst[7] = 1'b1;
        rounds(1);
        c_rst[7] = 1'b0;
        rounds(1);

        // Drop IC between edges part-way through a round.
        for (int i = 0; i < 10; i++) do_step(i == 0);
        @(negedge MCLK);
        slot_en = 1'b0;
        #2;
        IC = 1'b0;
        #1;
        chk_zero("ic_async");
        repeat (2) begin
            @(negedge MCLK); slot_en = 1'b1;
            @(negedge MCLK); slot_en = 1'b0;
        end
        chk_zero("ic_held");
        clear_model();
        @(negedge MCLK);
        IC = 1'b1;

        // Three un-synced steps, then sync realigns the slot labels.
        for (int i = 0; i < 3; i++) do_step(1'b0);
        rounds(3);

        // Drain the pipeline, then watch the outputs hold.
        use_gaps = 1'b0;
        do_step(1'b0);
        do_step(1'b0);
        @(negedge MCLK);
        slot_en = 1'b0;
        repeat (3) @(negedge MCLK);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
